mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multicycle multiply/divide controller for the E stage of the pipelined MIPS core.
- Decodes the MDU operation presented by E and starts a fixed-latency mult or div.
- Drives `busy`, which the stall logic uses to hold md/mt/mf instructions in D.
- Owns the architectural HI/LO registers; cancels not-yet-started operations when an exception or interrupt flushes E.

Parameters:
- MULT_CYCLES, 5: cycles `busy` stays high for mult/multu.
- DIV_CYCLES, 10: cycles `busy` stays high for div/divu.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7–15 treated as none.
- src_a  input  32  rs operand (forwarded).
- src_b  input  32  rt operand (forwarded).
- req  input  1  exception/interrupt flush of the E-stage instruction this cycle.
- start  output  1  combinational; high in the cycle a mult/div is accepted.
- busy  output  1  registered; high while an accepted mult/div is in flight.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset (synchronous): hi=0, lo=0, busy=0, cycle counter=0, pending HI/LO=0, state=IDLE. start=0 whenever reset=1.
- States: IDLE, RUN.
- Accept rule: start = (state==IDLE) & !busy & !req & !reset & md_op in {1,2,3,4}.
- IDLE → RUN on start. At that edge:
  - counter loads MULT_CYCLES or DIV_CYCLES, per op.
  - the full result is latched into pending_hi/pending_lo from src_a/src_b sampled in the start cycle.
- Cycle timing, issue at cycle T (start=1):
  - busy=1 in cycles T+1 … T+N.
  - counter decrements each RUN cycle.
  - on the edge ending cycle T+N: hi/lo take the pending values, busy→0, state→IDLE.
  - new hi/lo are visible in cycle T+N+1.
- hi/lo hold their old values throughout RUN.
- Arithmetic:
  - mult: signed 32x32 → 64, hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 → 64, same split.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (src_b==0, div or divu): the op is still accepted and busy runs the full DIV_CYCLES, but hi/lo are left unchanged at completion.
- mthi/mtlo: accepted only when state==IDLE & !req. hi (resp. lo) ← src_a at the next edge. No busy, no start.
- Ops presented while busy=1: ignored, with no state change. Stall logic must prevent this; the bench flags it as a protocol violation.
- req=1: suppresses start and mthi/mtlo for that cycle. An operation already in RUN is not cancelled; it completes and updates hi/lo, because it belongs to an older committed instruction.
- md_op values 0 and 7–15 have no effect.
- Reset mid-operation: the in-flight result is discarded. busy=0 and hi=lo=0 from the next cycle.
- Back-to-back: a new mult/div may start in cycle T+N+1, the first cycle with busy=0. There are no bubble cycles beyond that.

Test Plan:
1. mult src_a=0xFFFFFFFE (−2), src_b=3 at cycle T → start=1 at T; busy=1 for T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+6.
2. divu 100/7 at T → busy for 10 cycles; lo=14, hi=2 at T+11. Immediately follow with div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF ten cycles after its start.
3. mthi 0x1234 then mtlo 0x5678 in consecutive IDLE cycles → hi=0x1234, lo=0x5678, busy never asserted. Same ops with req=1 → hi/lo unchanged.
4. mult presented with req=1 → start=0, busy stays 0. Then req=1 asserted during cycle 3 of a running div → div still completes on schedule with the correct result.
5. div 5/0 with hi=0xAA, lo=0xBB preset → busy for 10 cycles, then hi=0xAA, lo=0xBB.
6. reset=1 in cycle 3 of a mult → next cycle busy=0, hi=lo=0. A fresh multu 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE after 5 busy cycles.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Multicycle multiply/divide controller for the E stage of the pipelined
// MIPS core. It decodes the MDU operation presented by E, starts a
// fixed-latency mult or div, raises busy for the stall logic while the
// operation is in flight, and owns the architectural HI/LO registers.
//
// Ports:
//   clk    in   1   system clock, all state on the rising edge
//   reset  in   1   synchronous, active-high reset
//   md_op  in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                   6 mtlo, 7-15 none
//   src_a  in  32   rs operand (forwarded)
//   src_b  in  32   rt operand (forwarded)
//   req    in   1   exception/interrupt flush of the E-stage instruction
//   start  out  1   combinational, high in the cycle a mult/div is accepted
//   busy   out  1   registered, high while an accepted mult/div is in flight
//   hi     out 32   architectural HI register
//   lo     out 32   architectural LO register

module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pending_hi;
  logic [31:0]      pending_lo;
  logic             pending_valid;

  logic        is_mult;
  logic        is_div;
  logic        div_by_zero;
  logic        div_overflow;
  logic [31:0] divisor_s;
  logic [31:0] divisor_u;
  logic [63:0] prod_signed;
  logic [63:0] prod_unsigned;
  logic [31:0] quot_signed;
  logic [31:0] rem_signed;
  logic [31:0] quot_unsigned;
  logic [31:0] rem_unsigned;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  assign is_mult      = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div       = (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign div_by_zero  = is_div && (src_b == 32'd0);
  assign div_overflow = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  // Dividing the most negative number by -1 gives the same answer as dividing
  // by 1 (quotient 0x80000000, remainder 0), so the overflow case is folded
  // into a divisor of 1. Divide by zero also uses 1 purely to keep the
  // divider well defined; that result is never committed.
  assign divisor_s = (src_b == 32'd0 || div_overflow) ? 32'd1 : src_b;
  assign divisor_u = (src_b == 32'd0) ? 32'd1 : src_b;

  assign prod_signed   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_unsigned = {32'd0, src_a} * {32'd0, src_b};
  assign quot_signed   = $signed(src_a) / $signed(divisor_s);
  assign rem_signed    = $signed(src_a) % $signed(divisor_s);
  assign quot_unsigned = src_a / divisor_u;
  assign rem_unsigned  = src_a % divisor_u;

  // Select the full 64-bit result of the operation being accepted this cycle.
  always_comb begin
    result_hi = 32'd0;
    result_lo = 32'd0;
    case (md_op)
      OP_MULT:  {result_hi, result_lo} = prod_signed;
      OP_MULTU: {result_hi, result_lo} = prod_unsigned;
      OP_DIV: begin
        result_hi = rem_signed;
        result_lo = quot_signed;
      end
      OP_DIVU: begin
        result_hi = rem_unsigned;
        result_lo = quot_unsigned;
      end
      default: begin
        result_hi = 32'd0;
        result_lo = 32'd0;
      end
    endcase
  end

  assign start = (state == IDLE) && !busy && !req && !reset && (is_mult || is_div);

  // Sequencer: the result is computed in the start cycle and parked in the
  // pending registers, then committed to HI/LO when the counter runs out so
  // the visible latency matches the fixed mult/div timing the stall logic
  // expects. req only blocks new work; a running op always completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      counter       <= '0;
      pending_hi    <= 32'd0;
      pending_lo    <= 32'd0;
      pending_valid <= 1'b0;
      hi            <= 32'd0;
      lo            <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            counter       <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pending_hi    <= result_hi;
            pending_lo    <= result_lo;
            pending_valid <= !div_by_zero;
          end else if (!req) begin
            if (md_op == OP_MTHI) begin
              hi <= src_a;
            end
            if (md_op == OP_MTLO) begin
              lo <= src_a;
            end
          end
        end
        RUN: begin
          if (counter == CNT_W'(1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
            if (pending_valid) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer
// Self-checking bench for mdu_sequencer. A table of mult/div vectors with
// hand-computed HI/LO results is issued back-to-back, followed by directed
// sequences for mthi/mtlo, flush (req), divide by zero and reset mid-op.
// Inputs change on the falling edge; outputs are checked there too, away
// from the rising edge where the DUT updates.

module tb_mdu_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        req;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int num_checks;
  int num_fails;

  // Bench-side view of the architectural HI/LO values.
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vector_t;

  vector_t vectors[9];

  mdu_sequencer #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md_op(md_op),
    .src_a(src_a),
    .src_b(src_b),
    .req  (req),
    .start(start),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence ever stalls on the clock.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic rq);
    md_op = op;
    src_a = a;
    src_b = b;
    req   = rq;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Issues a mult/div at the current negedge (cycle T) and follows it to
  // completion. Returns positioned at the negedge of cycle T+N+1 with idle
  // inputs, so a following call starts back-to-back. req_at>0 raises req
  // during busy cycle T+req_at.
  task automatic run_muldiv(input string name, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input int n, input int req_at);
    apply_stimulus(op, a, b, 1'b0);
    #1;
    check_output({name, " start"}, {31'd0, start}, 32'd1);
    step();
    apply_stimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i <= n; i++) begin
      req = (i == req_at);
      #1;
      check_output($sformatf("%s busy c%0d", name, i), {31'd0, busy}, 32'd1);
      check_output($sformatf("%s start c%0d", name, i), {31'd0, start}, 32'd0);
      check_output($sformatf("%s hi hold c%0d", name, i), hi, model_hi);
      check_output($sformatf("%s lo hold c%0d", name, i), lo, model_lo);
      step();
    end
    req = 1'b0;
    model_hi = exp_hi;
    model_lo = exp_lo;
    check_output({name, " busy done"}, {31'd0, busy}, 32'd0);
    check_output({name, " hi"}, hi, model_hi);
    check_output({name, " lo"}, lo, model_lo);
  endtask

  // Single-cycle op (mthi/mtlo/none/flushed) that must never start a run.
  task automatic run_single(input string name, input logic [3:0] op,
                            input logic [31:0] a, input logic rq,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    apply_stimulus(op, a, 32'd3, rq);
    #1;
    check_output({name, " start"}, {31'd0, start}, 32'd0);
    step();
    apply_stimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    model_hi = exp_hi;
    model_lo = exp_lo;
    check_output({name, " busy"}, {31'd0, busy}, 32'd0);
    check_output({name, " hi"}, hi, model_hi);
    check_output({name, " lo"}, lo, model_lo);
  endtask

  initial begin
    num_checks = 0;
    num_fails  = 0;
    model_hi   = 32'd0;
    model_lo   = 32'd0;

    vectors[0] = '{"mult -2*3",      OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N};
    vectors[1] = '{"divu 100/7",     OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_N};
    vectors[2] = '{"div -7/2",       OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vectors[3] = '{"multu max*max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULT_N};
    vectors[4] = '{"div min/-1",     OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_N};
    vectors[5] = '{"div 7/-2",       OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_N};
    vectors[6] = '{"mult 2^16*2^16", OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MULT_N};
    vectors[7] = '{"divu max/16",    OP_DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF, DIV_N};
    vectors[8] = '{"mult min*min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MULT_N};

    // Reset: a mult presented under reset must not start.
    reset = 1'b1;
    apply_stimulus(OP_MULT, 32'd5, 32'd6, 1'b0);
    step();
    #1;
    check_output("reset start", {31'd0, start}, 32'd0);
    step();
    check_output("reset busy", {31'd0, busy}, 32'd0);
    check_output("reset hi", hi, 32'd0);
    check_output("reset lo", lo, 32'd0);
    reset = 1'b0;
    apply_stimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    step();

    // Table vectors, issued back-to-back with no idle cycles between them.
    for (int v = 0; v < 9; v++) begin
      run_muldiv(vectors[v].name, vectors[v].op, vectors[v].a, vectors[v].b,
                 vectors[v].exp_hi, vectors[v].exp_lo, vectors[v].cycles, 0);
    end

    // mthi/mtlo in consecutive cycles, then flushed versions and no-op codes.
    run_single("mthi",           OP_MTHI, 32'h0000_1234, 1'b0, 32'h0000_1234, model_lo);
    run_single("mtlo",           OP_MTLO, 32'h0000_5678, 1'b0, 32'h0000_1234, 32'h0000_5678);
    run_single("mthi flushed",   OP_MTHI, 32'hDEAD_BEEF, 1'b1, 32'h0000_1234, 32'h0000_5678);
    run_single("mtlo flushed",   OP_MTLO, 32'hCAFE_F00D, 1'b1, 32'h0000_1234, 32'h0000_5678);
    run_single("op7 none",       4'd7,    32'h1111_1111, 1'b0, 32'h0000_1234, 32'h0000_5678);
    run_single("op15 none",      4'd15,   32'h2222_2222, 1'b0, 32'h0000_1234, 32'h0000_5678);

    // mult flushed by req: no start, busy stays low, HI/LO untouched.
    run_single("mult flushed",   OP_MULT, 32'd9,         1'b1, 32'h0000_1234, 32'h0000_5678);

    // req during busy cycle 3 of a div: the div still completes. -7/100? no: 100/-7.
    run_muldiv("div req mid-run", OP_DIV, 32'd100, 32'hFFFF_FFF9,
               32'h0000_0002, 32'hFFFF_FFF2, DIV_N, 3);

    // Divide by zero with HI/LO preset: full latency, values unchanged.
    run_single("preset hi", OP_MTHI, 32'h0000_00AA, 1'b0, 32'h0000_00AA, model_lo);
    run_single("preset lo", OP_MTLO, 32'h0000_00BB, 1'b0, 32'h0000_00AA, 32'h0000_00BB);
    run_muldiv("div 5/0", OP_DIV, 32'd5, 32'd0, 32'h0000_00AA, 32'h0000_00BB, DIV_N, 0);
    run_muldiv("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'h0000_00AA, 32'h0000_00BB, DIV_N, 0);

    // Reset during busy cycle 3 of a mult discards the in-flight result.
    apply_stimulus(OP_MULT, 32'd7, 32'd7, 1'b0);
    #1;
    check_output("rst-mult start", {31'd0, start}, 32'd1);
    step();
    apply_stimulus(OP_NONE, 32'd0, 32'd0, 1'b0);
    step();
    step();
    #1;
    check_output("rst-mult busy c3", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    check_output("rst-mult busy after", {31'd0, busy}, 32'd0);
    check_output("rst-mult hi after", hi, 32'd0);
    check_output("rst-mult lo after", lo, 32'd0);
    step();
    check_output("rst-mult busy stays low", {31'd0, busy}, 32'd0);
    check_output("rst-mult hi stays", hi, 32'd0);

    // Fresh multu after the reset.
    run_muldiv("multu max*2", OP_MULTU, 32'hFFFF_FFFF, 32'd2,
               32'h0000_0001, 32'hFFFF_FFFE, MULT_N, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
